// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampled UART transmitter:
// FSM state encodings, bit timing and data width constants, parity helper.
// The PARITY state exists only when UART_TX16_PARITY_EN is defined.
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;
    localparam int DATA_BITS     = 8;

    // Last tick of a bit, and the tick before it (used to register tx_done early).
    localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
    localparam logic [3:0] TICK_PRE  = 4'(TICKS_PER_BIT - 2);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX16_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

    // Even parity: XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO for uart_tx16: first-word-fall-through, power-of-two depth,
// pointers wrap naturally. A push while full is taken only when a pop happens
// on the same edge; a pop while empty is ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 bclk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic [4:0]           level
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [4:0]           level_r;
    logic                 full_r;
    logic                 empty_r;
    logic                 push_ok_s;
    logic                 pop_ok_s;
    logic [4:0]           level_n_s;

    // Qualify push/pop and compute the next occupancy.
    always_comb begin
        pop_ok_s  = pop && !empty_r;
        push_ok_s = push && (!full_r || pop_ok_s);
        level_n_s = level_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_n_s = level_r + 5'd1;
            2'b01:   level_n_s = level_r - 5'd1;
            default: level_n_s = level_r;
        endcase
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge bclk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= 5'd0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_n_s;
            full_r  <= (level_n_s == DEPTH_L);
            empty_r <= (level_n_s == 5'd0);
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge bclk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign level = level_r;

endmodule

// File: rtl/uart_tx16.sv
// UART transmitter, 8 data bits LSB first, one stop bit, 16 bclk per bit,
// fed from a byte FIFO. Frames run back-to-back while the FIFO has data.
// Optional even-parity bit between data and stop: define UART_TX16_PARITY_EN.
module uart_tx16
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       reset,
    input  logic       bclk,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic [4:0] level,
    output logic       txd,
    output logic       busy,
    output logic       tx_done,
    output logic       overflow
);

    tx_state_t            state_r, state_n_s;
    logic [3:0]           tick_r, tick_n_s;
    logic [2:0]           bit_idx_r, bit_idx_n_s;
    logic [DATA_BITS-1:0] shift_r, shift_n_s;
    logic                 txd_r, txd_n_s;
    logic                 busy_r, busy_n_s;
    logic                 tx_done_r, tx_done_n_s;
    logic                 overflow_r, overflow_n_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [DATA_BITS-1:0] fifo_dout_s;
`ifdef UART_TX16_PARITY_EN
    logic                 parity_r, parity_n_s;
`endif

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .bclk  (bclk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop_s),
        .din   (wr_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (level)
    );

    // Next-state, bit timing, shifter and line value for the frame FSM.
    always_comb begin
        state_n_s   = state_r;
        tick_n_s    = tick_r + 4'd1;
        bit_idx_n_s = bit_idx_r;
        shift_n_s   = shift_r;
        txd_n_s     = txd_r;
        pop_s       = 1'b0;
`ifdef UART_TX16_PARITY_EN
        parity_n_s  = parity_r;
`endif
        case (state_r)
            IDLE: begin
                tick_n_s = 4'd0;
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    shift_n_s  = fifo_dout_s;
`ifdef UART_TX16_PARITY_EN
                    parity_n_s = even_parity(fifo_dout_s);
`endif
                    txd_n_s    = 1'b0;
                    state_n_s  = START;
                end else begin
                    txd_n_s = 1'b1;
                end
            end
            START: begin
                if (tick_r == TICK_LAST) begin
                    txd_n_s   = shift_r[0];
                    state_n_s = DATA;
                end else begin
                    txd_n_s = 1'b0;
                end
            end
            DATA: begin
                if (tick_r == TICK_LAST) begin
                    shift_n_s = shift_r >> 1;
                    if (bit_idx_r == BIT_LAST) begin
                        bit_idx_n_s = 3'd0;
`ifdef UART_TX16_PARITY_EN
                        txd_n_s     = parity_r;
                        state_n_s   = PARITY;
`else
                        txd_n_s     = 1'b1;
                        state_n_s   = STOP;
`endif
                    end else begin
                        bit_idx_n_s = bit_idx_r + 3'd1;
                        txd_n_s     = shift_r[1];
                    end
                end else begin
                    shift_n_s = shift_r;
                end
            end
`ifdef UART_TX16_PARITY_EN
            PARITY: begin
                if (tick_r == TICK_LAST) begin
                    txd_n_s   = 1'b1;
                    state_n_s = STOP;
                end else begin
                    txd_n_s = parity_r;
                end
            end
`endif
            STOP: begin
                if (tick_r == TICK_LAST) begin
                    if (!fifo_empty_s) begin
                        pop_s      = 1'b1;
                        shift_n_s  = fifo_dout_s;
`ifdef UART_TX16_PARITY_EN
                        parity_n_s = even_parity(fifo_dout_s);
`endif
                        txd_n_s    = 1'b0;
                        state_n_s  = START;
                    end else begin
                        txd_n_s   = 1'b1;
                        state_n_s = IDLE;
                    end
                end else begin
                    txd_n_s = 1'b1;
                end
            end
            default: begin
                state_n_s   = IDLE;
                tick_n_s    = 4'd0;
                bit_idx_n_s = 3'd0;
                txd_n_s     = 1'b1;
            end
        endcase
        busy_n_s     = (state_n_s != IDLE);
        // Registered one cycle early so tx_done lines up with the last stop tick.
        tx_done_n_s  = (state_r == STOP) && (tick_r == TICK_PRE);
        overflow_n_s = wr_en && fifo_full_s && !pop_s;
    end

    // Frame FSM state and registered outputs.
    always_ff @(posedge bclk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            tick_r     <= 4'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= '0;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
            tx_done_r  <= 1'b0;
            overflow_r <= 1'b0;
`ifdef UART_TX16_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_n_s;
            tick_r     <= tick_n_s;
            bit_idx_r  <= bit_idx_n_s;
            shift_r    <= shift_n_s;
            txd_r      <= txd_n_s;
            busy_r     <= busy_n_s;
            tx_done_r  <= tx_done_n_s;
            overflow_r <= overflow_n_s;
`ifdef UART_TX16_PARITY_EN
            parity_r   <= parity_n_s;
`endif
        end
    end

    assign full     = fifo_full_s;
    assign txd      = txd_r;
    assign busy     = busy_r;
    assign tx_done  = tx_done_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx16.sv
// Self-checking bench for uart_tx16. A queue models the FIFO contents and the
// expected serial line is computed from the frame layout (start, 8 data bits
// LSB first, optional even parity, stop; 16 clocks per bit).
module tb_uart_tx16;

    localparam int DEPTH = 4;
`ifdef UART_TX16_PARITY_EN
    localparam int FRAME = 176;
`else
    localparam int FRAME = 160;
`endif

    logic       bclk    = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic [4:0] level;
    logic       txd;
    logic       busy;
    logic       tx_done;
    logic       overflow;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] model_q[$];
    logic [7:0] plan[int];
    logic [7:0] cur_b;

    uart_tx16 #(.FIFO_DEPTH(DEPTH)) dut (
        .reset    (reset),
        .bclk     (bclk),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .txd      (txd),
        .busy     (busy),
        .tx_done  (tx_done),
        .overflow (overflow)
    );

    always #5 bclk = ~bclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    // Expected line value k cycles after the start edge of a frame carrying b.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        int bi;
        bi = k / 16;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
`ifdef UART_TX16_PARITY_EN
        if (bi == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_txd"},     32'(txd),     32'd1);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_tx_done"}, 32'(tx_done), 32'd0);
        chk({tag, "_level"},   32'(level),   32'(model_q.size()));
    endtask

    // Single write while idle with an empty FIFO (no pop on this edge).
    task automatic do_write(input logic [7:0] b);
        logic acc;
        acc     = (model_q.size() < DEPTH);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
        if (acc) model_q.push_back(b);
        chk("wr_level",    32'(level),    32'(model_q.size()));
        chk("wr_overflow", 32'(overflow), 32'(!acc));
    endtask

    // Runs ncyc cycles of a frame whose start edge is the next edge; the byte
    // is popped from the model at that edge. Writes from plan[] are applied
    // at the matching cycle, including the pop edge itself.
    task automatic send_frame(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            logic exp_ovf;
            exp_ovf = 1'b0;
            if (k == 0) cur_b = model_q.pop_front();
            if (plan.exists(k)) begin
                wr_en   = 1'b1;
                wr_data = plan[k];
                if (model_q.size() < DEPTH) model_q.push_back(plan[k]);
                else exp_ovf = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            wr_en = 1'b0;
            chk("txd",      32'(txd),      32'(exp_line(cur_b, k)));
            chk("tx_done",  32'(tx_done),  32'(k == FRAME - 1));
            chk("busy",     32'(busy),     32'd1);
            chk("level",    32'(level),    32'(model_q.size()));
            chk("full",     32'(full),     32'(model_q.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
        end
        plan.delete();
    endtask

    task automatic drain();
        for (int f = 0; f < 2 * DEPTH && model_q.size() > 0; f++) begin
            send_frame(FRAME);
        end
        chk("drained", 32'(model_q.size()), 32'd0);
        tick();
        check_idle("after_drain");
    endtask

    initial begin
        // Reset values while reset is held low.
        #2 reset = 1'b0;
        #1;
        chk("rst_txd",      32'(txd),      32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_tx_done",  32'(tx_done),  32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_level",    32'(level),    32'd0);
        chk("rst_full",     32'(full),     32'd0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_idle("post_reset");

        // 0x55 from idle: txd low only after the following edge.
        do_write(8'h55);
        chk("txd_before_start", 32'(txd), 32'd1);
        send_frame(FRAME);
        tick();
        check_idle("after_55");

`ifdef UART_TX16_PARITY_EN
        do_write(8'h07);
        send_frame(FRAME);
        tick();
        check_idle("after_07");
`endif

        // Random bytes with random writes landing during frames.
        for (int r = 0; r < 3; r++) begin
            do_write(8'($urandom));
            for (int i = 0; i < 5; i++) begin
                plan[10 + 30 * i + int'($urandom_range(0, 20))] = 8'($urandom);
            end
            send_frame(FRAME);
            drain();
        end

        // Fill to full during a frame, then a dropped fifth write of 0xFF.
        do_write(8'h9C);
        plan[5] = 8'h01;
        plan[6] = 8'h02;
        plan[7] = 8'h03;
        plan[8] = 8'h04;
        plan[9] = 8'hFF;
        send_frame(FRAME);
        drain();

        // Write while full on the STOP->START pop edge: accepted, sent last.
        do_write(8'h5A);
        plan[3] = 8'h11;
        plan[4] = 8'h22;
        plan[5] = 8'h33;
        plan[6] = 8'h44;
        send_frame(FRAME);
        plan[0] = 8'hAB;
        send_frame(FRAME);
        drain();

        // Reset at cycle 70 of a 0xA3 frame with bytes queued behind it.
        do_write(8'hA3);
        plan[20] = 8'h66;
        plan[30] = 8'h77;
        send_frame(70);
        #2 reset = 1'b0;
        #1;
        model_q.delete();
        chk("midrst_txd",      32'(txd),      32'd1);
        chk("midrst_level",    32'(level),    32'd0);
        chk("midrst_full",     32'(full),     32'd0);
        chk("midrst_busy",     32'(busy),     32'd0);
        chk("midrst_tx_done",  32'(tx_done),  32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("inrst_tx_done", 32'(tx_done), 32'd0);
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_idle("post_midrst");
        end
        do_write(8'h3C);
        send_frame(FRAME);
        tick();
        check_idle("after_3c");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx16.md
UART_TX16 -- requirements
Module: uart_tx16

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port bclk  input  1  clock, 16x baud oversample clock.
REQ-004 SHALL have port wr_en  input  1  byte write strobe, sampled on posedge bclk.
REQ-005 SHALL have port wr_data  input  8  byte to transmit.
REQ-006 SHALL have port full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-007 SHALL have port level  output  5  FIFO occupancy, 0..FIFO_DEPTH.
REQ-008 SHALL have port txd  output  1  serial line, idle high, registered.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at end of each stop bit.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-012 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; every bit lasts exactly 16 bclk cycles, timed by a 4-bit tick counter.
REQ-013 SHALL move IDLE->START on the edge where level>0: pop one byte into the shift register, drive txd=0, clear tick counter, assert busy.
REQ-014 SHALL, for a write at edge N with the FIFO empty and the FSM in IDLE, drive txd low after edge N+1.
REQ-015 SHALL send 8 data bits LSB first in DATA, using a 3-bit bit index that wraps 7->0 on leaving DATA.
REQ-016 SHALL drive txd=1 in STOP for 16 cycles, pulse tx_done on the STOP cycle with tick==15, then go to START if level>0 (back-to-back, no idle gap), else to IDLE.
REQ-017 SHALL hold busy high from START entry until STOP exit, and low in IDLE.
REQ-018 SHALL accept a write when not full; SHALL accept a write while full only if a pop occurs on the same edge; otherwise SHALL drop the byte and pulse overflow.
REQ-019 SHALL, on simultaneous write and pop, keep level unchanged and preserve FIFO order.
REQ-020 SHALL wrap read/write pointers modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH or underflow.
REQ-021 SHALL not alter the frame in progress when the FIFO is written.

Reset
REQ-022 SHALL, on reset low, immediately force txd=1, busy=0, tx_done=0, overflow=0, level=0, full=0, pointers=0, state=IDLE, counters=0.
REQ-023 SHALL, on reset asserted mid-frame, abort the frame without completing the stop bit and discard all FIFO contents.

Configuration
REQ-024 SHALL, with macro UART_TX16_PARITY_EN defined, insert a PARITY state between DATA and STOP that sends the even-parity bit (XOR of the 8 data bits) for 16 cycles, giving 176-cycle frames.
REQ-025 SHALL, without UART_TX16_PARITY_EN, omit the PARITY state and its logic, giving 160-cycle frames (DATA->STOP).

Structure
REQ-026 SHALL take state encodings, the ticks-per-bit constant (16), and the data width (8) from shared package uart_pkg.
REQ-027 SHALL implement the FIFO as sub-module uart_tx_fifo (ports: push, pop, din, dout, full, empty, level); FSM and shifter stay in uart_tx16.

Verification
REQ-028 SHALL cover: write 0x55 while idle -> txd 0 for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then 1 for 16 cycles; tx_done at cycle 160 after the start edge.
REQ-029 SHALL cover: with UART_TX16_PARITY_EN, write 0x07 -> parity bit 1 after the data bits; tx_done at cycle 176.
REQ-030 SHALL cover: 4 writes 0x01..0x04 on consecutive cycles -> full=1, level=4; 5th write 0xFF while full -> overflow pulse; 4 frames sent back-to-back with no idle cycle between STOP and START; 0xFF never sent.
REQ-031 SHALL cover: FIFO full, write on the same edge as the STOP->START pop -> write accepted, level stays 4, byte sent last.
REQ-032 SHALL cover: reset asserted at cycle 70 of a 0xA3 frame -> txd=1 and level=0 immediately; no tx_done; after release, write 0x3C -> clean frame.
